keypad_operand_loader: RTL and testbench
========================================

Name: keypad_operand_loader

Overview:
Consumes the key code/flag stream produced by the matrix keypad scanner and turns it into clean key-press events. Digit keys enter two hex operands, A and B, one nibble at a time. On the start key, it serialises both operands LSB-first as a bit-pair stream for the serial adder. It sits between the keypad scanner and the serial adder datapath.

Parameters:
DATA_W, 8, operand width in bits; must be a multiple of 4 and at least 4
PRESS_CYC, 4, consecutive clk_in cycles with flag=1 and an unchanged code needed to accept a press
RELEASE_CYC, 4096, consecutive clk_in cycles with flag=0 needed to re-arm; must exceed the scanner's full 4-line scan period

Ports:
clk_in  in  1  system clock; the only clock
rst  in  1  synchronous, active-high reset
key_flag  in  1  scanner "key present" flag
key_code  in  5  scanner key code, 0..15 valid
key_evt  out  1  one-cycle pulse per accepted press
key_evt_code  out  4  code of the last accepted press
operand_a  out  DATA_W  operand A register
operand_b  out  DATA_W  operand B register
state_o  out  2  0=ENTER_A, 1=ENTER_B, 2=SHIFT, 3=DONE
busy  out  1  high while in SHIFT
bit_valid  out  1  a_bit/b_bit are valid this cycle
first_bit  out  1  high with bit 0; the adder clears its carry on this
a_bit  out  1  current bit of A
b_bit  out  1  current bit of B
done  out  1  one-cycle pulse on the SHIFT->DONE transition

Behaviour:
- Reset, synchronous on rst=1: all outputs and registers are 0; state is ENTER_A; the debouncer is armed. rst has priority over every other event, including mid-SHIFT.
- Input sampling: key_flag/key_code are registered once, a 1-cycle input delay, with no synchronizer stage.
- Press counter:
  - Increments while the registered flag=1 and the code equals the previous registered code.
  - Reloads to 1 on a code change or when the flag first rises.
  - Saturates at PRESS_CYC.
- Press acceptance: when the press counter reaches PRESS_CYC and the debouncer is armed, key_evt=1 for one cycle, key_evt_code=code[3:0], and the debouncer disarms.
- Release counter:
  - Counts consecutive flag=0 cycles and saturates.
  - Reaching RELEASE_CYC re-arms the debouncer.
  - Any flag=1 cycle resets it to 0, so the scanner's periodic flag gaps do not re-arm while a key is held.
- Key map: 0..9 are digits; 10 = next operand; 11 = start; 12 = clear; 13..15 are ignored.
- Digit entry: operand <= {operand[DATA_W-5:0], code[3:0]}; older nibbles fall off the top (wrap, no saturation).
- ENTER_A:
  - digit -> shift into A;
  - 10 -> ENTER_B;
  - 11 ignored;
  - 12 -> A=B=0, stay in ENTER_A.
- ENTER_B:
  - digit -> shift into B;
  - 10 ignored;
  - 11 -> SHIFT with bit index 0;
  - 12 -> A=B=0, ENTER_A.
- SHIFT:
  - Lasts exactly DATA_W cycles; on index i: bit_valid=1, a_bit=A[i], b_bit=B[i], first_bit=(i==0).
  - On the cycle after index DATA_W-1: state DONE, done=1 for one cycle, bit_valid=0.
  - key_evt still pulses, but every key event is discarded.
  - Operands are held unchanged.
- DONE:
  - operands are held;
  - digit -> A=B=0, then the digit is shifted into A, state ENTER_A;
  - 12 -> A=B=0, ENTER_A;
  - others ignored.
- Outputs when not in SHIFT: bit_valid, first_bit, a_bit and b_bit are 0.
- Latency: accepted press -> operand update on the next cycle; start key accepted -> first bit_valid on the next cycle.

Decomposition:
- Shared package holds:
  - the state enum (ENTER_A, ENTER_B, SHIFT, DONE);
  - key constants KEY_NEXT=10, KEY_START=11, KEY_CLR=12;
  - the code width of 5.
- Debouncing/event detection is a natural sub-module, key_event_debounce, outputting key_evt/key_evt_code.
- The FSM and the serialiser stay in the top module.

Test Plan:
- Press/release 3,5,10,2,11 with DATA_W=8 -> operand_a=0x35, operand_b=0x02. SHIFT then streams a_bit 1,0,1,0,1,1,0,0 and b_bit 0,1,0,0,0,0,0,0, first_bit on cycle 0 only, done one cycle after the 8th bit, state DONE.
- Code 7 bouncing flag 1,0,1 for 2-cycle pulses, then stable -> exactly one key_evt with code 7; no event during the bounce.
- Hold key 4 with the scanner's periodic flag gaps for 20000 cycles -> one key_evt only; a second press after RELEASE_CYC low cycles -> a second event.
- Digits 1,2,3 in ENTER_A (DATA_W=8) -> operand_a=0x23; then 12 -> A=B=0, ENTER_A.
- Press 9 during SHIFT -> key_evt pulses but operands and stream are unchanged; in DONE, press 6 -> A=0x06, B=0, ENTER_A.
- rst asserted at SHIFT bit index 3 -> next cycle all outputs 0, state ENTER_A, no done pulse.

Source files
------------

// File: rtl/keypad_operand_loader_pkg.sv
// Shared types and key constants for the keypad operand loader.
// The FSM state encoding matches the state_o output encoding.
package keypad_operand_loader_pkg;

    localparam int CODE_W = 5;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        SHIFT   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] KEY_NEXT  = 4'd10;
    localparam logic [3:0] KEY_START = 4'd11;
    localparam logic [3:0] KEY_CLR   = 4'd12;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/keypad_operand_loader_debounce.sv
// Turns the raw scanner flag/code stream into one pulse per accepted key press.
// A press needs PRESS_CYC stable cycles; re-arming needs RELEASE_CYC quiet cycles.
module key_event_debounce
    import keypad_operand_loader_pkg::*;
#(
    parameter int PRESS_CYC   = 4,
    parameter int RELEASE_CYC = 4096
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              key_flag,
    input  logic [CODE_W-1:0] key_code,
    output logic              key_evt,
    output logic [3:0]        key_evt_code
);

    localparam int PW = $clog2(PRESS_CYC + 1);
    localparam int RW = $clog2(RELEASE_CYC + 1);
    localparam logic [PW-1:0] PRESS_MAX   = PW'(PRESS_CYC);
    localparam logic [RW-1:0] RELEASE_MAX = RW'(RELEASE_CYC);

    logic              flag_r;
    logic              prev_flag_r;
    logic [CODE_W-1:0] code_r;
    logic [CODE_W-1:0] prev_code_r;
    logic [PW-1:0]     press_cnt_r;
    logic [PW-1:0]     press_cnt_s;
    logic [RW-1:0]     rel_cnt_r;
    logic [RW-1:0]     rel_cnt_s;
    logic              armed_r;
    logic              accept_s;
    logic              rearm_s;
    logic              key_evt_r;
    logic [3:0]        key_evt_code_r;

    // Input register plus one cycle of history for change detection
    always_ff @(posedge clk_in) begin
        if (rst) begin
            flag_r      <= 1'b0;
            code_r      <= '0;
            prev_flag_r <= 1'b0;
            prev_code_r <= '0;
        end else begin
            flag_r      <= key_flag;
            code_r      <= key_code;
            prev_flag_r <= flag_r;
            prev_code_r <= code_r;
        end
    end

    // Next values of the press and release counters
    always_comb begin
        press_cnt_s = '0;
        rel_cnt_s   = '0;
        if (!flag_r) begin
            press_cnt_s = '0;
        end else if (!prev_flag_r || (code_r != prev_code_r)) begin
            press_cnt_s = PW'(1);
        end else if (press_cnt_r < PRESS_MAX) begin
            press_cnt_s = press_cnt_r + PW'(1);
        end else begin
            press_cnt_s = press_cnt_r;
        end
        // Any flag=1 cycle restarts the quiet-time count, so scan gaps never re-arm
        if (flag_r) begin
            rel_cnt_s = '0;
        end else if (rel_cnt_r < RELEASE_MAX) begin
            rel_cnt_s = rel_cnt_r + RW'(1);
        end else begin
            rel_cnt_s = rel_cnt_r;
        end
        accept_s = (press_cnt_s == PRESS_MAX) && armed_r;
        rearm_s  = (rel_cnt_s == RELEASE_MAX);
    end

    // Counter state, arming and the registered event outputs
    always_ff @(posedge clk_in) begin
        if (rst) begin
            press_cnt_r    <= '0;
            rel_cnt_r      <= '0;
            armed_r        <= 1'b1;
            key_evt_r      <= 1'b0;
            key_evt_code_r <= 4'd0;
        end else begin
            press_cnt_r <= press_cnt_s;
            rel_cnt_r   <= rel_cnt_s;
            key_evt_r   <= accept_s;
            if (accept_s) begin
                key_evt_code_r <= code_r[3:0];
                armed_r        <= 1'b0;
            end else if (rearm_s) begin
                armed_r        <= 1'b1;
            end else begin
                armed_r        <= armed_r;
            end
        end
    end

    assign key_evt      = key_evt_r;
    assign key_evt_code = key_evt_code_r;

endmodule

// File: rtl/keypad_operand_loader.sv
// Collects two hex operands from key events and streams them LSB-first
// as bit pairs to the serial adder when the start key is pressed.
module keypad_operand_loader
    import keypad_operand_loader_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int PRESS_CYC   = 4,
    parameter int RELEASE_CYC = 4096
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              key_flag,
    input  logic [CODE_W-1:0] key_code,
    output logic              key_evt,
    output logic [3:0]        key_evt_code,
    output logic [DATA_W-1:0] operand_a,
    output logic [DATA_W-1:0] operand_b,
    output logic [1:0]        state_o,
    output logic              busy,
    output logic              bit_valid,
    output logic              first_bit,
    output logic              a_bit,
    output logic              b_bit,
    output logic              done
);

    localparam int IW = $clog2(DATA_W);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

    state_t            state_r;
    state_t            state_s;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [IW-1:0]     idx_r;
    logic              done_r;
    logic              evt_s;
    logic [3:0]        evt_code_s;

    function automatic logic [DATA_W-1:0] shift_nibble(input logic [DATA_W-1:0] op,
                                                       input logic [3:0] nib);
        logic [DATA_W-1:0] t;
        t      = op << 4;
        t[3:0] = nib;
        return t;
    endfunction

    key_event_debounce #(
        .PRESS_CYC  (PRESS_CYC),
        .RELEASE_CYC(RELEASE_CYC)
    ) u_debounce (
        .clk_in      (clk_in),
        .rst         (rst),
        .key_flag    (key_flag),
        .key_code    (key_code),
        .key_evt     (evt_s),
        .key_evt_code(evt_code_s)
    );

    // State register
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_r <= ENTER_A;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; every key event in SHIFT is discarded
    always_comb begin
        state_s = state_r;
        case (state_r)
            ENTER_A: begin
                if (evt_s && (evt_code_s == KEY_NEXT)) state_s = ENTER_B;
                else                                   state_s = ENTER_A;
            end
            ENTER_B: begin
                if (evt_s && (evt_code_s == KEY_START))    state_s = SHIFT;
                else if (evt_s && (evt_code_s == KEY_CLR)) state_s = ENTER_A;
                else                                       state_s = ENTER_B;
            end
            SHIFT: begin
                if (idx_r == LAST_IDX) state_s = DONE;
                else                   state_s = SHIFT;
            end
            DONE: begin
                if (evt_s && (is_digit(evt_code_s) || (evt_code_s == KEY_CLR))) state_s = ENTER_A;
                else                                                             state_s = DONE;
            end
            default: state_s = ENTER_A;
        endcase
    end

    // Operand registers, bit index and the done pulse
    always_ff @(posedge clk_in) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            idx_r  <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= (state_r == SHIFT) && (idx_r == LAST_IDX);
            idx_r  <= ((state_r == SHIFT) && (idx_r != LAST_IDX)) ? idx_r + IW'(1) : '0;
            if (evt_s && (evt_code_s == KEY_CLR) && (state_r != SHIFT)) begin
                a_r <= '0;
                b_r <= '0;
            end else if (evt_s && is_digit(evt_code_s)) begin
                case (state_r)
                    ENTER_A: a_r <= shift_nibble(a_r, evt_code_s);
                    ENTER_B: b_r <= shift_nibble(b_r, evt_code_s);
                    DONE: begin
                        a_r <= DATA_W'(evt_code_s);
                        b_r <= '0;
                    end
                    default: a_r <= a_r;
                endcase
            end else begin
                a_r <= a_r;
            end
        end
    end

    // Serial stream outputs, quiet outside SHIFT
    always_comb begin
        busy      = 1'b0;
        bit_valid = 1'b0;
        first_bit = 1'b0;
        a_bit     = 1'b0;
        b_bit     = 1'b0;
        if (state_r == SHIFT) begin
            busy      = 1'b1;
            bit_valid = 1'b1;
            first_bit = (idx_r == {IW{1'b0}});
            a_bit     = a_r[idx_r];
            b_bit     = b_r[idx_r];
        end else begin
            busy      = 1'b0;
        end
    end

    assign key_evt      = evt_s;
    assign key_evt_code = evt_code_s;
    assign operand_a    = a_r;
    assign operand_b    = b_r;
    assign state_o      = state_r;
    assign done         = done_r;

endmodule

// File: tb/tb_keypad_operand_loader.sv
// Randomized scoreboard bench for keypad_operand_loader: a key-level reference
// model predicts events, operands, state and the serial bit stream.
module tb_keypad_operand_loader;

    localparam int DW   = 32;
    localparam int PCYC = 4;
    localparam int RCYC = 16;

    logic          clk_in   = 1'b0;
    logic          rst      = 1'b1;
    logic          key_flag = 1'b0;
    logic [4:0]    key_code = 5'd0;
    logic          key_evt;
    logic [3:0]    key_evt_code;
    logic [DW-1:0] operand_a;
    logic [DW-1:0] operand_b;
    logic [1:0]    state_o;
    logic          busy, bit_valid, first_bit, a_bit, b_bit, done;

    keypad_operand_loader #(.DATA_W(DW), .PRESS_CYC(PCYC), .RELEASE_CYC(RCYC)) dut (
        .clk_in(clk_in), .rst(rst), .key_flag(key_flag), .key_code(key_code),
        .key_evt(key_evt), .key_evt_code(key_evt_code),
        .operand_a(operand_a), .operand_b(operand_b), .state_o(state_o),
        .busy(busy), .bit_valid(bit_valid), .first_bit(first_bit),
        .a_bit(a_bit), .b_bit(b_bit), .done(done)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [3:0]    code;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [1:0]    st;
    } evt_t;

    typedef struct packed {
        logic a;
        logic b;
        logic f;
    } bit_t;

    evt_t evt_q[$];
    bit_t bit_q[$];
    int checks    = 0;
    int failures  = 0;
    int done_seen = 0;
    int done_exp  = 0;

    // Reference model: 0=ENTER_A 1=ENTER_B 2=SHIFT 3=DONE
    logic [DW-1:0] m_a  = '0;
    logic [DW-1:0] m_b  = '0;
    int            m_st = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    task automatic model_key(input int code);
        evt_t e;
        bit_t bt;
        if (m_st == 0) begin
            if (code <= 9)        m_a = (m_a << 4) | DW'(code);
            else if (code == 10)  m_st = 1;
            else if (code == 12)  begin m_a = '0; m_b = '0; end
        end else if (m_st == 1) begin
            if (code <= 9)        m_b = (m_b << 4) | DW'(code);
            else if (code == 11) begin
                m_st = 2;
                for (int i = 0; i < DW; i++) begin
                    bt.a = m_a[i];
                    bt.b = m_b[i];
                    bt.f = (i == 0);
                    bit_q.push_back(bt);
                end
                done_exp++;
            end else if (code == 12) begin
                m_a = '0; m_b = '0; m_st = 0;
            end
        end else if (m_st == 3) begin
            if (code <= 9)        begin m_a = DW'(code); m_b = '0; m_st = 0; end
            else if (code == 12)  begin m_a = '0; m_b = '0; m_st = 0; end
        end
        e.code = 4'(code);
        e.a    = m_a;
        e.b    = m_b;
        e.st   = 2'(m_st);
        evt_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic press_hold(input int code, input int hold);
        key_code = 5'(code);
        key_flag = 1'b1;
        tick(hold);
    endtask

    task automatic release_key(input int low);
        key_flag = 1'b0;
        tick(low);
    endtask

    task automatic press(input int code);
        model_key(code);
        press_hold(code, 10);
        release_key(20);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((done_seen < done_exp) && (n < 300)) begin
            tick(1);
            n++;
        end
        check("done_count", done_seen, done_exp);
        m_st = 3;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_evt"},   key_evt, 0);
        check({tag, "_code"},  key_evt_code, 0);
        check({tag, "_a"},     operand_a, 0);
        check({tag, "_b"},     operand_b, 0);
        check({tag, "_state"}, state_o, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_bv"},    bit_valid, 0);
        check({tag, "_first"}, first_bit, 0);
        check({tag, "_abit"},  a_bit, 0);
        check({tag, "_bbit"},  b_bit, 0);
        check({tag, "_done"},  done, 0);
    endtask

    // Monitor: pops expectations whenever the DUT presents an event, a bit or done
    initial begin
        evt_t pend;
        evt_t e;
        bit_t bt;
        bit   pend_v = 1'b0;
        forever begin
            @(negedge clk_in);
            if (!rst) begin
                if (pend_v) begin
                    pend_v = 1'b0;
                    check("operand_a", operand_a, pend.a);
                    check("operand_b", operand_b, pend.b);
                    check("state_after_evt", state_o, pend.st);
                end
                if (key_evt) begin
                    check("evt_expected", evt_q.size() > 0, 1);
                    if (evt_q.size() > 0) begin
                        e = evt_q.pop_front();
                        check("evt_code", key_evt_code, e.code);
                        pend   = e;
                        pend_v = 1'b1;
                    end
                end
                if (bit_valid) begin
                    check("bit_expected", bit_q.size() > 0, 1);
                    check("busy", busy, 1);
                    if (bit_q.size() > 0) begin
                        bt = bit_q.pop_front();
                        check("a_bit", a_bit, bt.a);
                        check("b_bit", b_bit, bt.b);
                        check("first_bit", first_bit, bt.f);
                    end
                end
                if (done) begin
                    done_seen++;
                    check("done_state", state_o, 3);
                    check("done_bit_valid", bit_valid, 0);
                end
            end
        end
    end

    initial begin
        int n;
        int r;
        tick(3);
        @(negedge clk_in);
        check_zero("reset");
        tick(1);
        rst = 1'b0;
        tick(2);

        // Operands 0x35 / 0x02 and a full stream
        press(3); press(5); press(10); press(2); press(11);
        wait_done();
        check("tp_a", operand_a, 32'h35);
        check("tp_b", operand_b, 32'h02);
        check("tp_state", state_o, 2'd3);

        // Bouncing key 7 must give exactly one event
        model_key(7);
        key_code = 5'd7;
        for (int i = 0; i < 3; i++) begin
            key_flag = 1'b1; tick(2);
            key_flag = 1'b0; tick(2);
        end
        press_hold(7, 10);
        release_key(20);

        // Key 4 held with periodic scan gaps, then a real second press
        model_key(4);
        key_code = 5'd4;
        for (int c = 0; c < 20000; c++) begin
            key_flag = ((c % 16) < 13);
            tick(1);
        end
        release_key(20);
        press(4);

        // Digit entry then clear
        press(1); press(2); press(3); press(12);
        check("clr_a", operand_a, 0);
        check("clr_state", state_o, 0);

        // Key during SHIFT is discarded, digit in DONE restarts A
        press(8); press(10); press(1);
        model_key(11);
        press_hold(11, 6);
        release_key(18);
        press(9);
        wait_done();
        press(6);
        check("done_digit_a", operand_a, 32'h6);
        check("done_digit_b", operand_b, 32'h0);

        // Reset in the middle of the stream
        press(5); press(10); press(3);
        model_key(11);
        press_hold(11, 6);
        key_flag = 1'b0;
        n = 0;
        while (!first_bit && (n < 100)) begin
            @(negedge clk_in);
            n++;
        end
        check("first_bit_seen", first_bit, 1);
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        bit_q.delete();
        done_exp--;
        m_a = '0; m_b = '0; m_st = 0;
        @(negedge clk_in);
        check_zero("midrst");
        tick(1);
        release_key(20);

        // Structured random operand rounds
        for (int k = 0; k < 3; k++) begin
            n = $urandom_range(1, 10);
            for (int d = 0; d < n; d++) press($urandom_range(0, 9));
            if ($urandom_range(0, 1) == 1) press($urandom_range(13, 15));
            press(10);
            n = $urandom_range(1, 9);
            for (int d = 0; d < n; d++) press($urandom_range(0, 9));
            press(11);
            wait_done();
        end

        // Free random key sequence
        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(0, 19);
            press((r < 12) ? (r % 10) : (r - 4));
            if (m_st == 2) wait_done();
        end

        tick(5);
        check("evt_q_empty", evt_q.size(), 0);
        check("bit_q_empty", bit_q.size(), 0);
        check("done_total", done_seen, done_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
